gjc_ram_arbiter: RTL



---
 rtl/gjc_ram_arbiter_if.sv | 43 ++++
 rtl/gjc_ram_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/gjc_ram_arbiter_if.sv
// gjc_ram_arbiter_if: client and RAM-side signal bundle for gjc_ram_arbiter.
// slave = arbiter view, master = client/RAM view.
interface gjc_ram_arbiter_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
);
  logic                  INIT_DONE;
  logic                  WREQ0, WREQ1;
  logic [ADDR_WIDTH-1:0] WADDR0, WADDR1;
  logic [DATA_WIDTH-1:0] WDATA0, WDATA1;
  logic                  WGNT0, WGNT1;
  logic                  RREQ0, RREQ1;
  logic [ADDR_WIDTH-1:0] RADDR0, RADDR1;
  logic                  RGNT0, RGNT1;
  logic                  RVALID0, RVALID1;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RAM_WE;
  logic [ADDR_WIDTH-1:0] RAM_ADDRA;
  logic [DATA_WIDTH-1:0] RAM_DIN;
  logic                  RAM_RE;
  logic [ADDR_WIDTH-1:0] RAM_ADDRB;
  logic [DATA_WIDTH-1:0] RAM_DOUT;

  modport slave (
    output INIT_DONE,
    input  WREQ0, WREQ1, WADDR0, WADDR1, WDATA0, WDATA1,
    output WGNT0, WGNT1,
    input  RREQ0, RREQ1, RADDR0, RADDR1,
    output RGNT0, RGNT1, RVALID0, RVALID1, RDATA,
    output RAM_WE, RAM_ADDRA, RAM_DIN, RAM_RE, RAM_ADDRB,
    input  RAM_DOUT
  );

  modport master (
    input  INIT_DONE,
    output WREQ0, WREQ1, WADDR0, WADDR1, WDATA0, WDATA1,
    input  WGNT0, WGNT1,
    output RREQ0, RREQ1, RADDR0, RADDR1,
    input  RGNT0, RGNT1, RVALID0, RVALID1, RDATA,
    input  RAM_WE, RAM_ADDRA, RAM_DIN, RAM_RE, RAM_ADDRB,
    output RAM_DOUT
  );
endinterface

// File: rtl/gjc_ram_arbiter.sv
// gjc_ram_arbiter: zero-clears a dual-port RAM, then round-robin shares
// its write and read ports between two clients. Option: GJC_RAM_ARB_WR_BYPASS_EN
module gjc_ram_arbiter #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
) (
  input logic              CLK,
  input logic              RST,
  gjc_ram_arbiter_if.slave bus
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = '1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q, addra_q, addrb_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  done_q, we_q, re_q, rid_q;
  logic                  rv0_q, rv1_q, wptr_q, rptr_q;
  logic                  run, wgnt0, wgnt1, rgnt0, rgnt1;
  logic [ADDR_WIDTH-1:0] waddr_d, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // pointer value 0 favours client 0, 1 favours client 1
  assign run   = (state_q == S_RUN);
  assign wgnt0 = run & bus.WREQ0 & (~bus.WREQ1 | ~wptr_q);
  assign wgnt1 = run & bus.WREQ1 & (~bus.WREQ0 | wptr_q);
  assign rgnt0 = run & bus.RREQ0 & (~bus.RREQ1 | ~rptr_q);
  assign rgnt1 = run & bus.RREQ1 & (~bus.RREQ0 | rptr_q);

  assign waddr_d = wgnt1 ? bus.WADDR1 : bus.WADDR0;
  assign wdata_d = wgnt1 ? bus.WDATA1 : bus.WDATA0;
  assign raddr_d = rgnt1 ? bus.RADDR1 : bus.RADDR0;

  assign bus.WGNT0     = wgnt0;
  assign bus.WGNT1     = wgnt1;
  assign bus.RGNT0     = rgnt0;
  assign bus.RGNT1     = rgnt1;
  assign bus.INIT_DONE = done_q;
  assign bus.RAM_WE    = we_q;
  assign bus.RAM_ADDRA = addra_q;
  assign bus.RAM_DIN   = din_q;
  assign bus.RAM_RE    = re_q;
  assign bus.RAM_ADDRB = addrb_q;
  assign bus.RVALID0   = rv0_q;
  assign bus.RVALID1   = rv1_q;

  // clear sequencer, arbitration pointers and registered RAM/valid outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addra_q <= '0;
      din_q   <= '0;
      re_q    <= 1'b0;
      addrb_q <= '0;
      rid_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          we_q    <= 1'b1;
          addra_q <= cnt_q;
          din_q   <= '0;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_A) begin
            state_q <= S_RUN;
            done_q  <= 1'b1;
          end
        end
        S_RUN: begin
          we_q <= wgnt0 | wgnt1;
          if (wgnt0 | wgnt1) begin
            addra_q <= waddr_d;
            din_q   <= wdata_d;
            wptr_q  <= wgnt0;
          end
          re_q <= rgnt0 | rgnt1;
          if (rgnt0 | rgnt1) begin
            addrb_q <= raddr_d;
            rid_q   <= rgnt1;
            rptr_q  <= rgnt0;
          end
        end
      endcase
      rv0_q <= re_q & ~rid_q;
      rv1_q <= re_q & rid_q;
    end
  end

`ifdef GJC_RAM_ARB_WR_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] bdat_q;

  // capture a write that collides with a read issued in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      byp_q  <= 1'b0;
      bdat_q <= '0;
    end else begin
      byp_q  <= we_q & re_q & (addra_q == addrb_q);
      bdat_q <= din_q;
    end
  end

  assign bus.RDATA = byp_q ? bdat_q : bus.RAM_DOUT;
`else
  assign bus.RDATA = bus.RAM_DOUT;
`endif
endmodule
